// File: rtl/tube_pkg.sv
// -----------------------------------------------------------------------------
// tube_pkg
// Shared types and constants for the 2-digit 7-segment tube arbiter:
//   - arb_state_e  : arbiter FSM states (IDLE, SHOW)
//   - scan_state_e : digit scan FSM states (DIG0, BLANK0, DIG1, BLANK1)
//   - SEG_OFF      : all segments dark
//   - HEX_SEG      : hex digit -> {g,f,e,d,c,b,a} segment pattern, active-high
//   - cnt_width()  : counter width for a terminal count, never below 1 bit
// -----------------------------------------------------------------------------
package tube_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } arb_state_e;

  typedef enum logic [1:0] {
    DIG0,
    BLANK0,
    DIG1,
    BLANK1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // A limit of 1 still needs a 1-bit counter; $clog2(1) would give zero width.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/tube_scan_mux.sv
// -----------------------------------------------------------------------------
// tube_scan_mux
// Free-running digit scanner: DIG0 -> BLANK0 -> DIG1 -> BLANK1 -> DIG0.
// Each DIG state lasts SCAN_CYCLES, each BLANK state BLANK_CYCLES. Segments
// are forced dark in BLANK states and whenever i_blank is set.
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_byte         display byte; [3:0] on the low digit, [7:4] on the high digit
//   i_blank        force segments off
//   o_digitalTube  registered segments {g,f,e,d,c,b,a}, 1 = lit
//   o_sel          registered digit select, 0 = low digit, 1 = high digit
// -----------------------------------------------------------------------------
module tube_scan_mux
  import tube_pkg::*;
#(
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_blank,
  output logic [6:0] o_digitalTube,
  output logic       o_sel
);

  localparam int CNT_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_e      scan_q, scan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       seg_q, seg_d;
  logic             sel_q, sel_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    scan_d = scan_q;
    cnt_d  = cnt_q + CNT_W'(1);
    case (scan_q)
      DIG0:   if (cnt_q == SCAN_LAST)  begin scan_d = BLANK0; cnt_d = '0; end
      BLANK0: if (cnt_q == BLANK_LAST) begin scan_d = DIG1;   cnt_d = '0; end
      DIG1:   if (cnt_q == SCAN_LAST)  begin scan_d = BLANK1; cnt_d = '0; end
      BLANK1: if (cnt_q == BLANK_LAST) begin scan_d = DIG0;   cnt_d = '0; end
      default: begin scan_d = DIG0; cnt_d = '0; end
    endcase

    // Outputs are decoded from the next state so they line up with scan_q.
    // Select only moves when a DIG state is entered; the preceding BLANK
    // state has already darkened the segments under the old select.
    sel_d = (scan_d == DIG1) || (scan_d == BLANK1);
    seg_d = SEG_OFF;
    if (!i_blank) begin
      case (scan_d)
        DIG0:    seg_d = HEX_SEG[i_byte[3:0]];
        DIG1:    seg_d = HEX_SEG[i_byte[7:4]];
        default: seg_d = SEG_OFF;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_q <= DIG0;
      cnt_q  <= '0;
      seg_q  <= SEG_OFF;
      sel_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
    end
  end

  assign o_digitalTube = seg_q;
  assign o_sel         = sel_q;

endmodule

// File: rtl/tube_display_arbiter.sv
// -----------------------------------------------------------------------------
// tube_display_arbiter
// Round-robin owner selection for the 2-digit tube with a minimum hold time,
// plus the display byte register feeding the scan multiplexer.
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_req          per-requester level request
//   i_data         per-requester byte, requester k at [8k+7:8k]
//   o_grant        one-hot owner, zero when idle
//   o_digitalTube  segments {g,f,e,d,c,b,a}, 1 = lit
//   o_sel          digit select, 0 = low digit, 1 = high digit
// -----------------------------------------------------------------------------
module tube_display_arbiter
  import tube_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int HOLD_CYCLES  = 50000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [6:0]           o_digitalTube,
  output logic                 o_sel
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    owner_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [7:0]          byte_q;
  logic                blank_q;

  logic                any_req;
  logic [IDX_W-1:0]    win_d;
  logic [NUM_REQ-1:0]  win_onehot_d;
  logic [7:0]          owner_byte;

  // Round-robin pick starting at owner_q+1. Scanning from the farthest offset
  // down to the nearest lets the last hit win, i.e. the nearest requester.
  // The current/last owner sits at offset NUM_REQ and so has lowest priority.
  always_comb begin
    int cand;
    any_req      = |i_req;
    win_d        = owner_q;
    win_onehot_d = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(owner_q) + i) % NUM_REQ;
      if (i_req[cand]) win_d = IDX_W'(cand);
    end
    win_onehot_d[win_d] = 1'b1;
  end

  assign owner_byte = i_data[{owner_q, 3'b000} +: 8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= IDX_W'(NUM_REQ - 1);  // makes requester 0 the first pick
      grant_q <= '0;
      hold_q  <= '0;
      byte_q  <= '0;
      blank_q <= 1'b1;
    end else begin
      // Live tracking of the owner's byte; blanked whenever nobody owns it.
      blank_q <= (state_q != SHOW);
      if (state_q == SHOW) byte_q <= owner_byte;

      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (any_req) begin
            state_q <= SHOW;
            owner_q <= win_d;
            grant_q <= win_onehot_d;
          end else begin
            grant_q <= '0;
          end
        end

        SHOW: begin
          // Early release or hold expiry both re-arbitrate; the owner keeps
          // the grant only when nobody else is asking.
          if (!i_req[owner_q] || (hold_q == HOLD_LAST)) begin
            hold_q <= '0;
            if (any_req) begin
              owner_q <= win_d;
              grant_q <= win_onehot_d;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign o_grant = grant_q;

  tube_scan_mux #(
    .SCAN_CYCLES  (SCAN_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_byte        (byte_q),
    .i_blank       (blank_q),
    .o_digitalTube (o_digitalTube),
    .o_sel         (o_sel)
  );

endmodule

// File: tb/tb_tube_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tube_display_arbiter
// Directed bench for tube_display_arbiter with NUM_REQ=4, SCAN_CYCLES=4,
// BLANK_CYCLES=1, HOLD_CYCLES=8. After every reset the scan phase is fixed:
// k cycles after the last reset edge, k mod 10 = 0..3 DIG0, 4 BLANK0,
// 5..8 DIG1, 9 BLANK1. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tube_display_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int SCAN_CYCLES  = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int HOLD_CYCLES  = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ*8-1:0] data = '0;
  logic [NUM_REQ-1:0]   grant;
  logic [6:0]           tube;
  logic                 sel;

  int checks   = 0;
  int failures = 0;

  // Expected segments for k = 1..13 of the single-requester scenario
  // (data 8'h3A, switched to 8'h35 after sampling k = 11).
  logic [6:0] exp_t2 [13] = '{
    7'h00, 7'h00, 7'h77, 7'h00, 7'h4F, 7'h4F, 7'h4F,
    7'h4F, 7'h00, 7'h77, 7'h77, 7'h77, 7'h6D
  };

  tube_display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .SCAN_CYCLES  (SCAN_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_data        (data),
    .o_grant       (grant),
    .o_digitalTube (tube),
    .o_sel         (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Two reset edges; on return k = 0 (the last reset edge has just passed).
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;

    // ---- Reset, no requests: dark tube, select toggles every 5 cycles ----
    do_reset();
    check("rst_grant", 8'(grant), 8'h00);
    check("rst_tube",  8'(tube),  8'h00);
    check("rst_sel",   8'(sel),   8'h00);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("idle_grant_k%0d", k), 8'(grant), 8'h00);
      check($sformatf("idle_tube_k%0d", k),  8'(tube),  8'h00);
      check($sformatf("idle_sel_k%0d", k),   8'(sel),   ((k % 10) >= 5) ? 8'h01 : 8'h00);
    end

    // ---- Single requester 0, data 8'h3A, then live data change ----
    do_reset();
    req       = 4'b0001;
    data[7:0] = 8'h3A;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("t2_grant_k%0d", k), 8'(grant), 8'h01);
      check($sformatf("t2_tube_k%0d", k),  8'(tube),  8'(exp_t2[k-1]));
      check($sformatf("t2_sel_k%0d", k),   8'(sel),   ((k % 10) >= 5) ? 8'h01 : 8'h00);
      if (k == 11) data[7:0] = 8'h35;
    end

    // ---- All four requesting: strict rotation, 8 cycles each ----
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_g = 4'b0001 << (((k - 1) / 8) % 4);
      check($sformatf("rr_grant_k%0d", k), 8'(grant), 8'(exp_g));
    end

    // ---- Owner 0 drops at hold count 3 while requester 2 waits ----
    do_reset();
    req = 4'b0101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("drop_hold_k%0d", k), 8'(grant), 8'h01);
    end
    req = 4'b0100;
    tick();
    check("drop_release", 8'(grant), 8'h04);

    // ---- Sole requester 1 keeps the grant across hold expiry, no gap ----
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("solo_grant_k%0d", k), 8'(grant), 8'h02);
    end

    // ---- Reset in the middle of SHOW while DIG1 is lit ----
    do_reset();
    req       = 4'b0001;
    data[7:0] = 8'h3A;
    for (int k = 1; k <= 6; k++) tick();
    check("mid_pre_grant", 8'(grant), 8'h01);
    check("mid_pre_tube",  8'(tube),  8'h4F);
    check("mid_pre_sel",   8'(sel),   8'h01);
    rst = 1'b1;
    tick();
    check("mid_rst_grant", 8'(grant), 8'h00);
    check("mid_rst_tube",  8'(tube),  8'h00);
    check("mid_rst_sel",   8'(sel),   8'h00);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("post_rst_grant", 8'(grant), 8'h01);
    check("post_rst_tube",  8'(tube),  8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
